// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, sample-writer state
// encoding, and the address bit-reversal used by writer, reader and twiddle ROM.
package fft_pkg;

    localparam int FFT_ADDR_W    = 8;
    localparam int FFT_DATA_W    = 16;
    localparam int FFT_FRAME_LEN = 256;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FULL  = 2'd2
    } wr_state_t;

    typedef logic [FFT_ADDR_W-1:0] fft_addr_t;

    function automatic fft_addr_t bit_reverse(input fft_addr_t a);
        fft_addr_t r;
        for (int i = 0; i < FFT_ADDR_W; i++) begin
            r[i] = a[FFT_ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_rev_addr.sv
// Combinational ADDR_W-bit index reversal; BIT_REVERSE = 0 passes the index
// through unchanged for linear addressing.
module bit_rev_addr #(
    parameter int ADDR_W      = 8,
    parameter int BIT_REVERSE = 1
) (
    input  logic [ADDR_W-1:0] i_idx,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] w_rev;

    for (genvar g = 0; g < ADDR_W; g++) begin : g_rev
        assign w_rev[g] = i_idx[ADDR_W-1-g];
    end

    assign o_addr = (BIT_REVERSE != 0) ? w_rev : i_idx;

endmodule

// File: rtl/fft_sample_writer.sv
// Write-side front end of the FFT sample buffer: streams one frame into the
// block-RAM write port, pulses frame_done, then holds until frame_ack.
module fft_sample_writer
    import fft_pkg::*;
#(
    parameter int ADDR_W      = FFT_ADDR_W,
    parameter int DATA_W      = FFT_DATA_W,
    parameter int FRAME_LEN   = FFT_FRAME_LEN,
    parameter int BIT_REVERSE = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_mask,
    output logic              frame_done,
    input  logic              frame_ack,
    output logic [7:0]        frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    wr_state_t         r_state;
    wr_state_t         w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_addr;
    logic              w_xfer;
    logic              w_last;

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done;
    logic [7:0]        r_frame_cnt;

    bit_rev_addr #(
        .ADDR_W      (ADDR_W),
        .BIT_REVERSE (BIT_REVERSE)
    ) u_bit_rev_addr (
        .i_idx  (r_idx),
        .o_addr (w_addr)
    );

    assign w_xfer = in_valid && in_ready;
    assign w_last = w_xfer && (r_idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_FILL:  if (w_last)    w_next_state = ST_FLUSH;
            ST_FLUSH:                w_next_state = ST_FULL;
            ST_FULL:  if (frame_ack) w_next_state = ST_FILL;
            default:                 w_next_state = ST_FILL;
        endcase
    end

    // Ready is forced low while reset is held, not just after it releases.
    always_comb begin
        in_ready = 1'b0;
        if (RST_N && (r_state == ST_FILL)) begin
            in_ready = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_we   <= w_xfer;
            r_done <= (r_state == ST_FLUSH);
            if (w_xfer) begin
                r_waddr <= w_addr;
                r_wdata <= in_data;
                r_idx   <= w_last ? '0 : r_idx + ADDR_W'(1);
            end
            // Count moves with the entry into FULL, alongside frame_done.
            if (r_state == ST_FLUSH) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign ram_we     = r_we;
    assign ram_waddr  = r_waddr;
    assign ram_wdata  = r_wdata;
    assign ram_mask   = '0;
    assign frame_done = r_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fft_sample_writer.sv
// Bench for fft_sample_writer: a 256-entry bit-reversed instance (A) and a
// 16-entry linear instance (B) run side by side against a behavioural model.
module tb_fft_sample_writer;

    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n      [2];
    logic [DW-1:0] in_data    [2];
    logic          in_valid   [2];
    logic          in_ready   [2];
    logic [AW-1:0] ram_waddr  [2];
    logic [DW-1:0] ram_wdata  [2];
    logic          ram_we     [2];
    logic [DW-1:0] ram_mask   [2];
    logic          frame_done [2];
    logic          frame_ack  [2];
    logic [7:0]    frame_cnt  [2];

    fft_sample_writer #(
        .ADDR_W(8), .DATA_W(16), .FRAME_LEN(256), .BIT_REVERSE(1)
    ) u_dut_a (
        .CLK        (clk),
        .RST_N      (rst_n[0]),
        .in_data    (in_data[0]),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .ram_waddr  (ram_waddr[0]),
        .ram_wdata  (ram_wdata[0]),
        .ram_we     (ram_we[0]),
        .ram_mask   (ram_mask[0]),
        .frame_done (frame_done[0]),
        .frame_ack  (frame_ack[0]),
        .frame_cnt  (frame_cnt[0])
    );

    fft_sample_writer #(
        .ADDR_W(8), .DATA_W(16), .FRAME_LEN(16), .BIT_REVERSE(0)
    ) u_dut_b (
        .CLK        (clk),
        .RST_N      (rst_n[1]),
        .in_data    (in_data[1]),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .ram_waddr  (ram_waddr[1]),
        .ram_wdata  (ram_wdata[1]),
        .ram_we     (ram_we[1]),
        .ram_mask   (ram_mask[1]),
        .frame_done (frame_done[1]),
        .frame_ack  (frame_ack[1]),
        .frame_cnt  (frame_cnt[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: 0 = accepting, 1 = last write in flight, 2 = holding for ack.
    int            m_mode      [2];
    int            m_idx       [2];
    int            m_cnt       [2];
    logic          m_we        [2];
    int            m_waddr     [2];
    int            m_wdata     [2];
    logic          m_done      [2];
    int            t_last      [2];
    int            frames_done [2];
    int            fq_n        [2];
    logic [DW-1:0] fbuf        [2][256];
    logic [DW-1:0] ram_img     [2][256];
    int            src_cnt     [2];
    int            p_valid     [2];
    bit            ack_rand    [2];

    function automatic int flen(input int d);
        return (d == 0) ? 256 : 16;
    endfunction

    function automatic int exp_addr(input int d, input int i);
        int r;
        if (d != 0) return i;
        r = 0;
        for (int k = 0; k < 8; k++) r = r * 2 + ((i >> k) & 1);
        return r;
    endfunction

    function automatic string tg(input int d, input string s);
        return {(d == 0) ? "A." : "B.", s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit xfer [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check(tg(d, "ram_mask"), 32'(ram_mask[d]), 32'h0);
            check(tg(d, "in_ready"), 32'(in_ready[d]), 32'(rst_n[d] && (m_mode[d] == 0)));
            xfer[d] = in_valid[d] && rst_n[d] && (m_mode[d] == 0);
            if (xfer[d] && (m_idx[d] == flen(d) - 1)) t_last[d] = cyc;
            if (ram_we[d] === 1'b1) ram_img[d][ram_waddr[d]] = ram_wdata[d];
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                m_mode[d] = 0; m_idx[d] = 0; m_cnt[d] = 0; m_we[d] = 1'b0;
                m_waddr[d] = 0; m_wdata[d] = 0; m_done[d] = 1'b0; fq_n[d] = 0;
            end else begin
                m_we[d]   = xfer[d];
                m_done[d] = (m_mode[d] == 1);
                if (xfer[d]) begin
                    m_waddr[d] = exp_addr(d, m_idx[d]);
                    m_wdata[d] = int'(in_data[d]);
                    if (fq_n[d] < 256) begin
                        fbuf[d][fq_n[d]] = in_data[d];
                        fq_n[d]++;
                    end
                end
                case (m_mode[d])
                    0: if (xfer[d]) begin
                        if (m_idx[d] == flen(d) - 1) begin
                            m_idx[d]  = 0;
                            m_mode[d] = 1;
                        end else begin
                            m_idx[d]++;
                        end
                    end
                    1: begin
                        m_mode[d] = 2;
                        m_cnt[d]  = (m_cnt[d] + 1) % 256;
                    end
                    default: if (frame_ack[d]) m_mode[d] = 0;
                endcase
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check(tg(d, "ram_we"),     32'(ram_we[d]),     32'(m_we[d]));
            check(tg(d, "ram_waddr"),  32'(ram_waddr[d]),  32'(m_waddr[d]));
            check(tg(d, "ram_wdata"),  32'(ram_wdata[d]),  32'(m_wdata[d]));
            check(tg(d, "frame_done"), 32'(frame_done[d]), 32'(m_done[d]));
            check(tg(d, "frame_cnt"),  32'(frame_cnt[d]),  32'(m_cnt[d]));
            if (frame_done[d] === 1'b1) check(tg(d, "done_latency"), 32'(cyc - t_last[d]), 32'd2);
            if (m_done[d]) begin
                check(tg(d, "frame_len"), 32'(fq_n[d]), 32'(flen(d)));
                for (int i = 0; i < fq_n[d]; i++) begin
                    check(tg(d, "frame_data"), 32'(ram_img[d][exp_addr(d, i)]), 32'(fbuf[d][i]));
                end
                fq_n[d] = 0;
                frames_done[d]++;
            end
            // Source holds data and valid until the sample is taken.
            if (xfer[d]) begin
                if (d == 0) begin
                    src_cnt[0]++;
                    in_data[0] = 16'(src_cnt[0]);
                end else begin
                    in_data[1] = 16'($urandom);
                end
                in_valid[d] = ($urandom_range(99) < p_valid[d]);
            end else if (!in_valid[d]) begin
                in_valid[d] = ($urandom_range(99) < p_valid[d]);
            end
            if (ack_rand[d]) frame_ack[d] = ($urandom_range(3) == 0);
        end
    endtask

    task automatic wait_frames(input int d, input int target, input int budget);
        int n = 0;
        while (frames_done[d] < target && n < budget) begin
            step();
            n++;
        end
        check(tg(d, "frame_wait"), 32'(frames_done[d] >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; frame_ack[d] = 1'b0;
            m_mode[d] = 0; m_idx[d] = 0; m_cnt[d] = 0; m_we[d] = 1'b0;
            m_waddr[d] = 0; m_wdata[d] = 0; m_done[d] = 1'b0;
            t_last[d] = 0; frames_done[d] = 0; fq_n[d] = 0; src_cnt[d] = 0;
        end
        p_valid[0] = 100; p_valid[1] = 60;
        ack_rand[0] = 1'b0; ack_rand[1] = 1'b1;
        in_data[0] = 16'h0000; in_valid[0] = 1'b1;
        in_data[1] = 16'($urandom); in_valid[1] = 1'b0;

        repeat (3) step();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Frame 1 on A: samples 0x0000..0x00FF back-to-back, bit-reversed.
        wait_frames(0, 1, 400);
        check("A.addr_of_sample1",   32'(ram_img[0][8'h80]), 32'h0001);
        check("A.addr_of_sample2",   32'(ram_img[0][8'h40]), 32'h0002);
        check("A.addr_of_sample255", 32'(ram_img[0][8'hFF]), 32'h00FF);
        check("A.frame_cnt_after1",  32'(frame_cnt[0]),      32'd1);

        // Hold for 10 cycles with valid high, then release.
        repeat (10) step();
        check("A.held_not_ready", 32'(in_ready[0]), 32'd0);
        frame_ack[0] = 1'b1;
        step();
        frame_ack[0] = 1'b0;
        step();
        check("A.restart_we",    32'(ram_we[0]),    32'd1);
        check("A.restart_waddr", 32'(ram_waddr[0]), 32'h00);
        check("A.restart_wdata", 32'(ram_wdata[0]), 32'h0100);

        // Ack held through FILL and FLUSH, still high on the done cycle.
        frame_ack[0] = 1'b1;
        wait_frames(0, 2, 400);
        step();
        check("A.ack_with_done", 32'(in_ready[0]), 32'd1);
        frame_ack[0] = 1'b0;

        // Reset after 100 samples of frame 3.
        n = 0;
        while (m_idx[0] != 100 && n < 400) begin
            step();
            n++;
        end
        check("A.reached_100", 32'(m_idx[0]), 32'd100);
        rst_n[0] = 1'b0;
        step();
        check("A.rst_cancels_we", 32'(ram_we[0]),    32'd0);
        check("A.rst_frame_cnt",  32'(frame_cnt[0]), 32'd0);
        rst_n[0] = 1'b1;
        step();
        check("A.post_rst_we",    32'(ram_we[0]),    32'd1);
        check("A.post_rst_waddr", 32'(ram_waddr[0]), 32'h00);
        frame_ack[0] = 1'b1;
        wait_frames(0, 3, 400);
        step();
        frame_ack[0] = 1'b0;

        // B runs continuously with random gaps and acks until the counter wraps.
        wait_frames(1, 256, 30000);
        check("B.frame_cnt_wrap0", 32'(frame_cnt[1]), 32'd0);
        wait_frames(1, 257, 400);
        check("B.frame_cnt_wrap1", 32'(frame_cnt[1]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
